ctrl_sequencer: RTL and testbench

Hardwired control unit for the 32-bit bus datapath: a Moore FSM that fetches an instruction through PC/MAR/MDR/IR and executes three-register ALU instructions as T0–T5 control steps. It drives the datapath's one-hot bus-source select, per-register load enables, ALU select, memory read and PC increment. It replaces hand-sequenced stimulus and sits directly beside the datapath at the top level.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/ctrl_decode.sv | 25 ++
 rtl/ctrl_sequencer.sv | 122 ++++++++++++
 tb/tb_ctrl_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_HALT,
        ST_FAULT
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_SEL_ADD  = 5'd1;
    localparam logic [4:0] ALU_SEL_SUB  = 5'd2;
    localparam logic [4:0] ALU_SEL_AND  = 5'd3;
    localparam logic [4:0] ALU_SEL_OR   = 5'd4;
    localparam logic [4:0] ALU_SEL_IDLE = 5'd7;

    // Bus-source and load-enable positions share one index space.
    localparam int IDX_ZLO = 19;
    localparam int IDX_PC  = 20;
    localparam int IDX_IR  = 21;
    localparam int IDX_MDR = 22;
    localparam int IDX_MAR = 23;
    localparam int IDX_Y   = 24;

    function automatic logic [31:0] onehot32(input logic [3:0] reg_idx);
        onehot32 = 32'd1 << reg_idx;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: supported ALU op, halt, and ALU select.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic       supported_o,
    output logic       is_halt_o,
    output logic [4:0] alu_sel_o
);

    always_comb begin
        supported_o = 1'b0;
        is_halt_o   = 1'b0;
        alu_sel_o   = ALU_SEL_IDLE;
        case (opcode_i)
            OP_ADD:  begin supported_o = 1'b1; alu_sel_o = ALU_SEL_ADD; end
            OP_SUB:  begin supported_o = 1'b1; alu_sel_o = ALU_SEL_SUB; end
            OP_AND:  begin supported_o = 1'b1; alu_sel_o = ALU_SEL_AND; end
            OP_OR:   begin supported_o = 1'b1; alu_sel_o = ALU_SEL_OR;  end
            OP_HALT: is_halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore control FSM for the 32-bit bus datapath (fetch + 3-register ALU ops).
// Define CTRL_MEM_WAIT_EN to hold T1 until mem_ready.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter logic [4:0] ALU_IDLE = 5'd7
) (
    input  logic        Clock,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [31:0] bus_sel,
    output logic [31:0] reg_enable,
    output logic [4:0]  alu_sel,
    output logic        read,
    output logic        inc_pc,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
);

    state_e     state_q, state_d;
    logic       op_supported, op_halt;
    logic [4:0] op_alu_sel;
    logic [3:0] ra, rb, rc;

    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];

    ctrl_decode u_decode (
        .opcode_i    (ir[31:27]),
        .supported_o (op_supported),
        .is_halt_o   (op_halt),
        .alu_sel_o   (op_alu_sel)
    );

`ifdef CTRL_MEM_WAIT_EN
    logic unused_bits;
    assign unused_bits = ^ir[14:0];
`else
    logic unused_bits;
    assign unused_bits = ^{ir[14:0], mem_ready};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
`ifdef CTRL_MEM_WAIT_EN
            ST_T1:    if (mem_ready) state_d = ST_T2;
`else
            ST_T1:    state_d = ST_T2;
`endif
            ST_T2:    state_d = ST_T3;
            ST_T3: begin
                if (op_supported)  state_d = ST_T4;
                else if (op_halt)  state_d = ST_HALT;
                else               state_d = ST_FAULT;
            end
            ST_T4:    state_d = ST_T5;
            ST_T5:    state_d = run ? ST_T0 : ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Outputs decode from the registered state; ir is stable from T3 onward.
    always_comb begin
        bus_sel    = '0;
        reg_enable = '0;
        alu_sel    = ALU_IDLE;
        read       = 1'b0;
        inc_pc     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_T0: begin
                bus_sel[IDX_PC]     = 1'b1;
                reg_enable[IDX_MAR] = 1'b1;
                inc_pc              = 1'b1;
            end
            ST_T1: begin
                read                = 1'b1;
                reg_enable[IDX_MDR] = 1'b1;
            end
            ST_T2: begin
                bus_sel[IDX_MDR]    = 1'b1;
                reg_enable[IDX_IR]  = 1'b1;
            end
            ST_T3: begin
                if (op_supported) begin
                    bus_sel           = onehot32(rb);
                    reg_enable[IDX_Y] = 1'b1;
                end
            end
            ST_T4: begin
                bus_sel             = onehot32(rc);
                reg_enable[IDX_ZLO] = 1'b1;
                alu_sel             = op_alu_sel;
            end
            ST_T5: begin
                bus_sel[IDX_ZLO]    = 1'b1;
                reg_enable          = onehot32(ra);
                instr_done          = 1'b1;
            end
            ST_HALT:  halted  = 1'b1;
            ST_FAULT: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: vector table, directed corner cases, random vs. model.
module tb_ctrl_sequencer;

    typedef struct packed {
        logic [31:0] bus;
        logic [31:0] en;
        logic [4:0]  alu;
        logic        rd;
        logic        inc;
        logic        done;
        logic        hlt;
        logic        ill;
    } outs_t;

    typedef struct {
        logic        c;
        logic        r;
        logic [31:0] w;
        outs_t       e;
    } vec_t;

    logic        Clock = 1'b0;
    logic        clr = 1'b1, run = 1'b0, mem_ready = 1'b1;
    logic [31:0] ir = '0;
    logic [31:0] bus_sel, reg_enable;
    logic [4:0]  alu_sel;
    logic        read, inc_pc, instr_done, halted, illegal;
    outs_t       got;

    int total = 0;
    int bad   = 0;
    // Model position: -1 idle, 0..5 = step Tn of the instruction, 10 halted, 11 faulted.
    int m_k   = -1;

    always #5 Clock = ~Clock;

    ctrl_sequencer dut (
        .Clock(Clock), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
        .bus_sel(bus_sel), .reg_enable(reg_enable), .alu_sel(alu_sel),
        .read(read), .inc_pc(inc_pc), .instr_done(instr_done),
        .halted(halted), .illegal(illegal)
    );

    assign got = {bus_sel, reg_enable, alu_sel, read, inc_pc, instr_done, halted, illegal};

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00011: return 5'd1;
            5'b00100: return 5'd2;
            5'b01001: return 5'd3;
            5'b01010: return 5'd4;
            default:  return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input int ra, input int rb, input int rc);
        logic [3:0] a, b, c;
        a = ra[3:0]; b = rb[3:0]; c = rc[3:0];
        return {op, a, b, c, 15'd0};
    endfunction

    function automatic outs_t model_out(input int k, input logic [31:0] w);
        outs_t o;
        o = '0;
        o.alu = 5'd7;
        case (k)
            0: begin o.bus = 32'd1 << 20; o.en = 32'd1 << 23; o.inc = 1'b1; end
            1: begin o.rd = 1'b1; o.en = 32'd1 << 22; end
            2: begin o.bus = 32'd1 << 22; o.en = 32'd1 << 21; end
            3: if (alu_of(w[31:27]) != 5'd0) begin
                   o.bus = 32'd1 << w[22:19]; o.en = 32'd1 << 24;
               end
            4: begin o.bus = 32'd1 << w[18:15]; o.en = 32'd1 << 19; o.alu = alu_of(w[31:27]); end
            5: begin o.bus = 32'd1 << 19; o.en = 32'd1 << w[26:23]; o.done = 1'b1; end
            10: o.hlt = 1'b1;
            11: o.ill = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic chk_o(input string nm, input outs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs, take one edge, advance the model, settle 1 time unit.
    task automatic drive(input logic c, input logic r, input logic m, input logic [31:0] w);
        clr = c; run = r; mem_ready = m; ir = w;
        @(posedge Clock);
        if (c) m_k = -1;
        else begin
            case (m_k)
                -1: if (r) m_k = 0;
                1: begin
`ifdef CTRL_MEM_WAIT_EN
                    if (m) m_k = 2;
`else
                    m_k = 2;
`endif
                end
                3: begin
                    if (alu_of(w[31:27]) != 5'd0) m_k = 4;
                    else if (w[31:27] == 5'b11011) m_k = 10;
                    else m_k = 11;
                end
                5: m_k = r ? 0 : -1;
                10, 11: ;
                default: m_k = m_k + 1;
            endcase
        end
        #1;
    endtask

    task automatic step(input logic c, input logic r, input logic m, input logic [31:0] w, input string nm);
        drive(c, r, m, w);
        chk_o(nm, model_out(m_k, w));
    endtask

    vec_t tbl[9];
    outs_t rst_o;

    initial begin
        logic [31:0] w;
        int dones;

        rst_o = '0; rst_o.alu = 5'd7;

        // AND R5,R2,R4 with run dropped in T4: finish through T5, then idle.
        w = 32'h4A920000;
        tbl[0] = '{1'b1, 1'b0, w, rst_o};
        tbl[1] = '{1'b0, 1'b1, w, {32'h0010_0000, 32'h0080_0000, 5'd7, 5'b01000}};
        tbl[2] = '{1'b0, 1'b1, w, {32'h0000_0000, 32'h0040_0000, 5'd7, 5'b10000}};
        tbl[3] = '{1'b0, 1'b1, w, {32'h0040_0000, 32'h0020_0000, 5'd7, 5'b00000}};
        tbl[4] = '{1'b0, 1'b1, w, {32'h0000_0004, 32'h0100_0000, 5'd7, 5'b00000}};
        tbl[5] = '{1'b0, 1'b0, w, {32'h0000_0010, 32'h0008_0000, 5'd3, 5'b00000}};
        tbl[6] = '{1'b0, 1'b0, w, {32'h0008_0000, 32'h0000_0020, 5'd7, 5'b00100}};
        tbl[7] = '{1'b0, 1'b0, w, rst_o};
        tbl[8] = '{1'b0, 1'b0, w, rst_o};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].c, tbl[i].r, 1'b1, tbl[i].w);
            chk_o($sformatf("vec%0d", i), tbl[i].e);
        end

        // Back-to-back ADDs: T0 follows T5 directly, instr_done every 6 cycles.
        w = mk(5'b00011, 1, 2, 3);
        drive(1'b1, 1'b0, 1'b1, w);
        dones = 0;
        for (int i = 1; i <= 13; i++) begin
            step(1'b0, 1'b1, 1'b1, w, "b2b_model");
            if (i <= 12 && instr_done) dones++;
            if (i == 6 || i == 12) chk32("b2b_done", {31'd0, instr_done}, 32'd1);
            if (i == 7) chk32("b2b_t0_bus", bus_sel, 32'd1 << 20);
        end
        chk32("b2b_done_count", dones, 2);

        // HALT opcode: T3 silent, then halted held until clr.
        w = mk(5'b11011, 3, 4, 5);
        drive(1'b1, 1'b0, 1'b1, w);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 1'b1, w, "halt_model");
            if (i == 4) chk32("halt_t3_quiet", bus_sel | reg_enable, 32'd0);
            if (i >= 5) chk32("halt_held", {31'd0, halted}, 32'd1);
        end
        drive(1'b1, 1'b1, 1'b1, w);
        chk_o("halt_clr", rst_o);

        // Illegal opcode: fault, no load enables after T2.
        w = mk(5'b11111, 6, 7, 8);
        drive(1'b1, 1'b0, 1'b1, w);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 1'b1, w, "ill_model");
            if (i >= 4) chk32("ill_no_en", reg_enable, 32'd0);
            if (i >= 5) chk32("ill_flag", {31'd0, illegal}, 32'd1);
        end

        // clr in T4 (clr beats run): destination R6 never enabled.
        w = mk(5'b00100, 6, 1, 2);
        drive(1'b1, 1'b0, 1'b1, w);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b1, w, "clr_t4_model");
        chk32("clr_t4_in_t4", reg_enable, 32'd1 << 19);
        drive(1'b1, 1'b1, 1'b1, w);
        chk_o("clr_t4_idle", rst_o);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, w, "clr_t4_after");
            chk32("clr_t4_no_dest", {31'd0, reg_enable[6]}, 32'd0);
        end

        // T1 length with mem_ready low.
        w = mk(5'b01010, 2, 3, 4);
        drive(1'b1, 1'b0, 1'b0, w);
        step(1'b0, 1'b1, 1'b0, w, "mw_t0");
        step(1'b0, 1'b1, 1'b0, w, "mw_t1");
        chk32("mw_read0", {31'd0, read}, 32'd1);
`ifdef CTRL_MEM_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, w, "mw_hold");
            chk32("mw_read_held", {31'd0, read}, 32'd1);
        end
        step(1'b0, 1'b1, 1'b1, w, "mw_release");
        chk32("mw_t2_bus", bus_sel, 32'd1 << 22);
`else
        step(1'b0, 1'b1, 1'b0, w, "mw_ignored");
        chk32("mw_t2_bus", bus_sel, 32'd1 << 22);
`endif

        // Random run/clr/mem_ready and instruction stream against the model.
        drive(1'b1, 1'b0, 1'b1, w);
        for (int i = 0; i < 600; i++) begin
            logic c, r, m;
            int pick;
            c = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 2) != 0);
            if (!(m_k >= 3 && m_k <= 5)) begin
                pick = $urandom_range(0, 19);
                case (pick)
                    0:       w = mk(5'b11011, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
                    1:       w = {5'b11111, 27'($urandom)};
                    default: w = mk(pick[0] ? 5'b00011 : (pick[1] ? 5'b00100 : (pick[2] ? 5'b01001 : 5'b01010)),
                                    $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15))
                                 | {17'd0, 15'($urandom)};
                endcase
            end
            step(c, r, m, w, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
